// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter and its helpers.
package mem_arb_pkg;

    localparam int MAX_WAIT_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_DM = 3'd2,
        RESP    = 3'd3,
        ERR     = 3'd4
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for bus masters: clear wins over enable, and expired_o
// flags the enabled cycle whose increment brings the count up to LIMIT.
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CW'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && !clr_i && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and the memory stage, with a
// timeout trap. Define MEM_ARB_ROUND_ROBIN_EN for alternating grants on a tie.
//
// Handshake: a requester raises x_req with stable address/data and holds it until
// it sees a one-cycle x_done; the memory sees mem_req with stable mem_* fields and
// finishes the access in the cycle it drives mem_ready=1.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_f,
    output logic          stall_m,
    output logic          timeout_err,
    output state_t        dbg_state_o
);

    state_t        state_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          if_done_q;
    logic          dm_done_q;
    logic          timeout_err_q;

    logic busy;
    logic gnt_dm;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    assign busy = (state_q == BUSY_IF) || (state_q == BUSY_DM);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_t last_gnt_q;

    // On a tie, hand the port to whoever did not get it last time.
    assign gnt_dm = dm_req && (!if_req || (last_gnt_q == GNT_IF));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_gnt_q <= GNT_IF;
        end else if ((state_q == IDLE) && (dm_req || if_req)) begin
            last_gnt_q <= gnt_dm ? GNT_DM : GNT_IF;
        end
    end
`else
    assign gnt_dm = dm_req;
`endif

    assign tmr_clr = (state_q == IDLE) || (busy && mem_ready);
    assign tmr_en  = busy && !mem_ready;

    mem_wait_timer #(
        .LIMIT(MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            if_done_q     <= 1'b0;
            dm_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_dm) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                        state_q     <= BUSY_DM;
                    end else if (if_req) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        state_q     <= BUSY_IF;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                        if (state_q == BUSY_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_done_q  <= 1'b1;
                        end else begin
                            dm_rdata_q <= mem_we_q ? '0 : mem_rdata;
                            dm_done_q  <= 1'b1;
                        end
                    end else if (tmr_expired) begin
                        mem_req_q     <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= ERR;
                    end
                end
                // Requests are deliberately ignored here so a req still high
                // during its own done cycle does not start a second access.
                RESP: begin
                    if_done_q <= 1'b0;
                    dm_done_q <= 1'b0;
                    state_q   <= IDLE;
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_done     = if_done_q;
    assign dm_done     = dm_done_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state_o = state_q;

    assign stall_f = if_req && !if_done_q;
    assign stall_m = dm_req && !dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie, store wait states, mem_ready
// outside BUSY, timeout, reset mid-access and (when built with it) round robin.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 15;

  logic          clk;
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall_f;
  logic          stall_m;
  logic          timeout_err;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_done(if_done),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .dm_done(dm_done),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall_f(stall_f),
    .stall_m(stall_m),
    .timeout_err(timeout_err),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs are checked 1 ns later
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0;
    if_addr = '0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_addr = '0;
    dm_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    settle();
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_if_done", 64'(if_done), 64'd0);
    check("rst_dm_done", 64'(dm_done), 64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_dm_rdata", 64'(dm_rdata), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);

    // fetch only, ready on first mem_req cycle
    cyc(); if_req = 1'b1; if_addr = 32'h40; settle();
    check("f_c0_state", 64'(dbg_state), 64'(IDLE));
    check("f_c0_stall_f", 64'(stall_f), 64'd1);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'hE3A01005; settle();
    check("f_c1_state", 64'(dbg_state), 64'(BUSY_IF));
    check("f_c1_mem_req", 64'(mem_req), 64'd1);
    check("f_c1_mem_we", 64'(mem_we), 64'd0);
    check("f_c1_mem_addr", 64'(mem_addr), 64'h40);
    check("f_c1_stall_f", 64'(stall_f), 64'd1);
    cyc(); mem_ready = 1'b0; mem_rdata = '0; settle();
    check("f_c2_if_done", 64'(if_done), 64'd1);
    check("f_c2_if_rdata", 64'(if_rdata), 64'hE3A01005);
    check("f_c2_mem_req", 64'(mem_req), 64'd0);
    check("f_c2_stall_f", 64'(stall_f), 64'd0);
    check("f_c2_dm_done", 64'(dm_done), 64'd0);
    if_req = 1'b0;
    cyc(); settle();
    check("f_c3_if_done", 64'(if_done), 64'd0);
    check("f_c3_state", 64'(dbg_state), 64'(IDLE));
    check("f_c3_if_rdata_hold", 64'(if_rdata), 64'hE3A01005);

    // simultaneous: data wins, fetch follows in the next IDLE
    cyc(); if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; settle();
    check("s_c0_state", 64'(dbg_state), 64'(IDLE));
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h55; settle();
    check("s_c1_state", 64'(dbg_state), 64'(BUSY_DM));
    check("s_c1_mem_addr", 64'(mem_addr), 64'h100);
    check("s_c1_mem_we", 64'(mem_we), 64'd0);
    check("s_c1_stall_f", 64'(stall_f), 64'd1);
    check("s_c1_stall_m", 64'(stall_m), 64'd1);
    cyc(); mem_ready = 1'b0; mem_rdata = '0; settle();
    check("s_c2_dm_done", 64'(dm_done), 64'd1);
    check("s_c2_dm_rdata", 64'(dm_rdata), 64'h55);
    check("s_c2_if_done", 64'(if_done), 64'd0);
    check("s_c2_stall_m", 64'(stall_m), 64'd0);
    check("s_c2_stall_f", 64'(stall_f), 64'd1);
    dm_req = 1'b0;
    cyc(); settle();
    check("s_c3_state", 64'(dbg_state), 64'(IDLE));
    check("s_c3_stall_f", 64'(stall_f), 64'd1);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h12345678; settle();
    check("s_c4_state", 64'(dbg_state), 64'(BUSY_IF));
    check("s_c4_mem_addr", 64'(mem_addr), 64'h80);
    check("s_c4_stall_f", 64'(stall_f), 64'd1);
    cyc(); mem_ready = 1'b0; mem_rdata = '0; settle();
    check("s_c5_if_done", 64'(if_done), 64'd1);
    check("s_c5_if_rdata", 64'(if_rdata), 64'h12345678);
    check("s_c5_dm_rdata_hold", 64'(dm_rdata), 64'h55);
    if_req = 1'b0;
    cyc(); settle();
    check("s_c6_state", 64'(dbg_state), 64'(IDLE));

    // store with 4 wait-state cycles; read data on the bus must not leak into dm_rdata
    cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; settle();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      mem_ready = (i == 4);
      mem_rdata = 32'hAAAAAAAA;
      settle();
      check($sformatf("w_c%0d_state", i), 64'(dbg_state), 64'(BUSY_DM));
      check($sformatf("w_c%0d_mem_req", i), 64'(mem_req), 64'd1);
      check($sformatf("w_c%0d_mem_we", i), 64'(mem_we), 64'd1);
      check($sformatf("w_c%0d_mem_addr", i), 64'(mem_addr), 64'h200);
      check($sformatf("w_c%0d_mem_wdata", i), 64'(mem_wdata), 64'hDEADBEEF);
      check($sformatf("w_c%0d_dm_done", i), 64'(dm_done), 64'd0);
      check($sformatf("w_c%0d_stall_m", i), 64'(stall_m), 64'd1);
    end
    cyc(); mem_ready = 1'b0; settle();
    check("w_c5_dm_done", 64'(dm_done), 64'd1);
    check("w_c5_dm_rdata", 64'(dm_rdata), 64'd0);
    check("w_c5_mem_req", 64'(mem_req), 64'd0);
    dm_req = 1'b0; dm_we = 1'b0;

    // mem_ready while IDLE is ignored
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h99; settle();
    check("i_c0_state", 64'(dbg_state), 64'(IDLE));
    cyc(); mem_ready = 1'b0; settle();
    check("i_c1_state", 64'(dbg_state), 64'(IDLE));
    check("i_c1_if_done", 64'(if_done), 64'd0);
    check("i_c1_dm_done", 64'(dm_done), 64'd0);
    check("i_c1_if_rdata", 64'(if_rdata), 64'h12345678);

    // timeout: 15 BUSY cycles then ERR, sticky until reset
    cyc(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_ready = 1'b0; settle();
    for (int i = 1; i <= MAX_WAIT; i++) begin
      cyc(); settle();
      check($sformatf("t_c%0d_state", i), 64'(dbg_state), 64'(BUSY_DM));
      check($sformatf("t_c%0d_timeout", i), 64'(timeout_err), 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      check($sformatf("t_err%0d_state", i), 64'(dbg_state), 64'(ERR));
      check($sformatf("t_err%0d_timeout", i), 64'(timeout_err), 64'd1);
      check($sformatf("t_err%0d_mem_req", i), 64'(mem_req), 64'd0);
      check($sformatf("t_err%0d_stall_m", i), 64'(stall_m), 64'd1);
      check($sformatf("t_err%0d_dm_done", i), 64'(dm_done), 64'd0);
    end
    cyc(); reset_n = 1'b0;
    cyc(); reset_n = 1'b1; dm_req = 1'b0; settle();
    check("t_rst_timeout", 64'(timeout_err), 64'd0);
    check("t_rst_state", 64'(dbg_state), 64'(IDLE));

    // reset in the second BUSY_IF cycle abandons the access
    cyc(); if_req = 1'b1; if_addr = 32'h44; settle();
    cyc(); settle();
    check("r_c1_state", 64'(dbg_state), 64'(BUSY_IF));
    cyc(); reset_n = 1'b0; settle();
    check("r_c2_state", 64'(dbg_state), 64'(BUSY_IF));
    cyc(); reset_n = 1'b1; if_req = 1'b0; settle();
    check("r_c3_mem_req", 64'(mem_req), 64'd0);
    check("r_c3_state", 64'(dbg_state), 64'(IDLE));
    check("r_c3_if_done", 64'(if_done), 64'd0);
    cyc(); settle();
    check("r_c4_if_done", 64'(if_done), 64'd0);
    check("r_c4_mem_req", 64'(mem_req), 64'd0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // both requesting continuously: DM, IF, DM, IF, one done every 3 cycles
    do_reset();
    cyc(); if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
    mem_ready = 1'b1; mem_rdata = 32'h77; settle();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rr%0d_idle", g), 64'(dbg_state), 64'(IDLE));
      cyc(); settle();
      check($sformatf("rr%0d_busy", g), 64'(dbg_state), (g % 2 == 0) ? 64'(BUSY_DM) : 64'(BUSY_IF));
      check($sformatf("rr%0d_addr", g), 64'(mem_addr), (g % 2 == 0) ? 64'h600 : 64'h500);
      cyc(); settle();
      check($sformatf("rr%0d_dm_done", g), 64'(dm_done), (g % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d_if_done", g), 64'(if_done), (g % 2 == 0) ? 64'd0 : 64'd1);
      cyc(); settle();
    end
    idle_inputs();
`endif

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads and stores).
- Sequences each access over a variable-latency req/ready handshake.
- Drives stall requests, which the hazard logic ORs into its StallF/StallD/StallE/StallM decisions.
- Detects a memory that never answers and latches an error.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 15, maximum cycles to wait for mem_ready; must be ≥1. The counter width is $clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch requests a read; held until if_done.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched instruction; valid while if_done=1.
- if_done  out  1  one-cycle completion pulse to fetch.
- dm_req  in  1  data access request; held until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid while dm_done=1.
- dm_done  out  1  one-cycle completion pulse to the memory stage.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  AW  address to memory.
- mem_wdata  out  DW  write data to memory.
- mem_rdata  in  DW  read data; valid when mem_ready=1.
- mem_ready  in  1  access complete this cycle.
- stall_f  out  1  fetch must hold.
- stall_m  out  1  memory stage must hold (freezes the older pipeline stages).
- timeout_err  out  1  sticky; memory failed to respond.

Behaviour:
- Reset (reset_n=0 at a clock edge) overrides everything, including an access in progress:
  - state=IDLE, wait counter=0, last-grant=IF.
  - mem_req=0, if_done=dm_done=0, if_rdata=dm_rdata=0, timeout_err=0.
  - The outstanding memory access is abandoned, with no done pulse.
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP, ERR.
- IDLE:
  - If dm_req=1, latch dm_we/dm_addr/dm_wdata into the mem_* registers and go to BUSY_DM.
  - Else if if_req=1, latch if_addr with mem_we=0 and go to BUSY_IF.
  - Else stay in IDLE.
  - Data always wins a tie (base build).
- BUSY_x:
  - mem_req=1; mem_we/mem_addr/mem_wdata are registered and held stable for the whole access.
  - On mem_ready=1: capture mem_rdata into the x_rdata register, clear the counter, go to RESP.
  - Otherwise increment the counter. When the counter equals MAX_WAIT and mem_ready=0, go to ERR.
- RESP:
  - mem_req=0; the granted requester's done=1 for exactly this cycle.
  - For a store, dm_rdata=0.
  - Next state is always IDLE. Requests are not sampled in RESP, so a req still high during its own done cycle is not treated as a new access.
- ERR:
  - mem_req=0, timeout_err=1, no done pulses.
  - Stalls remain asserted; the state is held until reset.
- Latency:
  - Request seen in IDLE at cycle 0; mem_req=1 from cycle 1.
  - If mem_ready=1 in cycle k≥1, done=1 in cycle k+1.
  - Minimum 2 cycles; peak throughput is one access per 3 cycles.
- Stalls (combinational):
  - stall_f = if_req & ~if_done.
  - stall_m = dm_req & ~dm_done.
  - A fetch held off by a data access keeps stall_f=1 until its own done.
- mem_ready outside BUSY_x is ignored.
- if_rdata/dm_rdata hold their last value outside their done cycle.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when if_req and dm_req are both high in IDLE, grant the requester not in last-grant. Last-grant updates on every grant. Single requests behave as in the base build.
- Undefined: fixed data priority, and the last-grant register is not instantiated.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, BUSY_IF, BUSY_DM, RESP, ERR).
  - grant_t enum (GNT_IF, GNT_DM).
  - default MAX_WAIT constant.
- One sub-module, mem_wait_timer: parameterised counter with clear, enable and an expired output; reused by later bus masters.

Test Plan:
- Fetch only: if_req=1, addr 0x40; mem_ready=1 on the first mem_req cycle, rdata 0xE3A01005 → if_done=1 at cycle 2 with if_rdata=0xE3A01005; stall_f=1 in cycles 0–1.
- Simultaneous: if_req=dm_req=1, load 0x100 returning 0x55 → the load is served first with dm_done and dm_rdata=0x55. The fetch is granted in the following IDLE cycle; stall_f stays high throughout.
- Store with wait states: dm_we=1, addr 0x200, wdata 0xDEADBEEF, mem_ready delayed 4 cycles → mem_* held stable for 4 cycles, dm_done one cycle after ready, dm_rdata=0.
- Timeout: mem_ready tied 0 → after 15 BUSY cycles enter ERR. timeout_err=1 sticky, mem_req=0, stall_m stays 1; after reset_n=0 for one edge, timeout_err=0.
- Reset mid-access: reset_n=0 in the second BUSY_IF cycle → next cycle mem_req=0, state IDLE, no if_done pulse.
- With MEM_ARB_ROUND_ROBIN_EN: both requesting continuously → grants alternate DM, IF, DM, IF, with one done every 3 cycles.
